// File: rtl/pin_entry_fsm_pkg.sv
// pin_pkg: shared state encoding, digit width and legal-digit helper for the PIN entry block
package pin_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  function automatic logic is_legal_digit(input logic [DIGIT_W-1:0] d);
    return d <= MAX_DIGIT;
  endfunction
endpackage

// File: rtl/pin_entry_fsm_timer.sv
// pin_timer: load/clear/enable up-counter with a terminal-count compare against a runtime limit
module pin_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == limit;
endmodule

// File: rtl/pin_entry_fsm.sv
// pin_entry_fsm: keypad PIN compare with unlock/fail pulses, failure counting, lockout and entry timeout
module pin_entry_fsm
  import pin_pkg::*;
#(
  parameter int PIN_LEN        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  localparam int CW = $clog2(PIN_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [DIGIT_W-1:0]         key_digit,
  input  logic                       key_clear,
  input  logic [DIGIT_W*PIN_LEN-1:0] pin_ref,
  output logic                       unlock_pulse,
  output logic                       fail_pulse,
  output logic                       locked,
  output logic [CW-1:0]              digit_count,
  output logic                       busy
);
  localparam int PW = DIGIT_W * PIN_LEN;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2((LOCK_CYCLES > TIMEOUT_CYCLES ? LOCK_CYCLES : TIMEOUT_CYCLES) + 1);
  state_t         state, nxt;
  logic [PW-1:0]  ref_q;
  logic [FW-1:0]  fail_cnt;
  logic           mismatch, tc, legal, miss, last, lock_now;
  assign legal    = key_valid && is_legal_digit(key_digit);
  // ref_q is shifted left per accepted digit so the digit to compare is always in the MSBs
  assign miss     = key_digit != (state == IDLE ? pin_ref[PW-1 -: DIGIT_W] : ref_q[PW-1 -: DIGIT_W]);
  assign last     = digit_count == CW'(PIN_LEN - 1);
  assign lock_now = mismatch && (int'(fail_cnt) + 1 >= MAX_TRIES);
  always_comb
    nxt = state == IDLE  ? (legal ? ENTRY : IDLE) :
          state == ENTRY ? (key_clear ? IDLE : legal ? (last ? CHECK : ENTRY) : tc ? IDLE : ENTRY) :
          state == CHECK ? (lock_now ? LOCKOUT : IDLE) :
                           (tc ? IDLE : LOCKOUT);
  pin_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (nxt != state),
    .load     (state == ENTRY && legal),
    .en       (state == ENTRY || state == LOCKOUT),
    .load_val ('0),
    .limit    (state == LOCKOUT ? TW'(LOCK_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1)),
    .tc       (tc)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      ref_q        <= '0;
      fail_cnt     <= '0;
      mismatch     <= 1'b0;
      unlock_pulse <= 1'b0;
      fail_pulse   <= 1'b0;
      locked       <= 1'b0;
      digit_count  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      busy         <= nxt == ENTRY || nxt == CHECK;
      unlock_pulse <= state == CHECK && !mismatch;
      fail_pulse   <= state == CHECK && mismatch;
      case (state)
        IDLE:
          if (legal) begin
            ref_q       <= pin_ref << DIGIT_W;
            mismatch    <= miss;
            digit_count <= CW'(1);
          end
        ENTRY:
          if (key_clear || (!legal && tc)) digit_count <= '0;
          else if (legal) begin
            digit_count <= digit_count + 1'b1;
            mismatch    <= mismatch | miss;
            ref_q       <= ref_q << DIGIT_W;
          end
        CHECK: begin
          digit_count <= '0;
          locked      <= lock_now;
          fail_cnt    <= !mismatch ? '0 : lock_now ? FW'(MAX_TRIES) : fail_cnt + 1'b1;
        end
        default:
          if (tc) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_pin_entry_fsm.sv
// tb_pin_entry_fsm: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_pin_entry_fsm;
  localparam int LOCK = 20, TMO = 10, TRIES = 3;
  logic        clk = 1'b0, reset = 1'b0, key_valid = 1'b0, key_clear = 1'b0;
  logic [3:0]  key_digit = '0;
  logic [15:0] pin_ref = 16'h1234;
  logic        unlock_pulse, fail_pulse, locked, busy;
  logic [2:0]  digit_count;
  int total = 0, bad = 0;
  int m_cnt, m_idle, m_fails, m_lockrem;
  bit m_mis, m_check, m_unlock, m_fail, m_locked;
  logic [15:0] m_ref;
  typedef struct {bit kv; logic [3:0] kd; bit kc; bit eu; bit ef; bit el; int ec;} vec_t;
  vec_t tv[$];

  pin_entry_fsm #(.PIN_LEN(4), .MAX_TRIES(TRIES), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear),
    .pin_ref(pin_ref), .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse), .locked(locked),
    .digit_count(digit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_idle = 0; m_fails = 0; m_lockrem = 0;
    m_mis = 0; m_check = 0; m_unlock = 0; m_fail = 0; m_locked = 0; m_ref = '0;
  endtask

  // One clock edge of the PIN rules: entered digit count, idle count, failures and lockout time left
  task automatic model(input bit kv, input logic [3:0] kd, input bit kc);
    bit legal;
    legal = kv && kd <= 4'd9;
    m_unlock = 0; m_fail = 0;
    if (m_lockrem > 0) begin
      m_lockrem--;
      if (m_lockrem == 0) begin m_locked = 0; m_fails = 0; end
    end else if (m_check) begin
      m_check = 0; m_cnt = 0;
      if (m_mis) begin
        m_fail = 1; m_fails++;
        if (m_fails >= TRIES) begin m_locked = 1; m_lockrem = LOCK; end
      end else begin
        m_unlock = 1; m_fails = 0;
      end
    end else if (m_cnt == 0) begin
      if (legal) begin m_ref = pin_ref; m_mis = kd != m_ref[15:12]; m_cnt = 1; m_idle = 0; end
    end else if (kc) m_cnt = 0;
    else if (legal) begin
      m_mis = m_mis | (kd != m_ref[(3-m_cnt)*4 +: 4]);
      m_cnt++; m_idle = 0;
      if (m_cnt == 4) m_check = 1;
    end else begin
      m_idle++;
      if (m_idle == TMO) m_cnt = 0;
    end
  endtask

  task automatic step(input bit kv, input logic [3:0] kd, input bit kc);
    key_valid = kv; key_digit = kd; key_clear = kc;
    @(posedge clk);
    model(kv, kd, kc);
    #1;
    chk("unlock", unlock_pulse, m_unlock);
    chk("fail", fail_pulse, m_fail);
    chk("locked", locked, m_locked);
    chk("count", digit_count, m_cnt);
    chk("busy", busy, m_cnt > 0);
    key_valid = 0; key_clear = 0;
  endtask

  task automatic enter(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) step(1, pin[(3-i)*4 +: 4], 0);
    step(0, 0, 0);
  endtask

  task automatic async_reset();
    #2 reset = 0;
    #1;
    chk("rst_unlock", unlock_pulse, 0);
    chk("rst_fail", fail_pulse, 0);
    chk("rst_locked", locked, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_busy", busy, 0);
    model_clear();
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    int n;
    logic [3:0] d;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_count", digit_count, 0);
    chk("reset_busy", busy, 0);
    reset = 1;
    // Test 1 (1234 unlock), test 2 (1235 fail then 1234 unlock), test 5 (clear beats key, digit 12 ignored)
    tv = '{'{1, 1, 0, 0, 0, 0, 1}, '{1, 2, 0, 0, 0, 0, 2}, '{1, 3, 0, 0, 0, 0, 3}, '{1, 4, 0, 0, 0, 0, 4},
           '{0, 0, 0, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0},
           '{1, 1, 0, 0, 0, 0, 1}, '{1, 2, 0, 0, 0, 0, 2}, '{1, 3, 0, 0, 0, 0, 3}, '{1, 5, 0, 0, 0, 0, 4},
           '{0, 0, 0, 0, 1, 0, 0},
           '{1, 1, 0, 0, 0, 0, 1}, '{1, 2, 0, 0, 0, 0, 2}, '{1, 3, 0, 0, 0, 0, 3}, '{1, 4, 0, 0, 0, 0, 4},
           '{0, 0, 0, 1, 0, 0, 0},
           '{1, 1, 0, 0, 0, 0, 1}, '{1, 2, 0, 0, 0, 0, 2}, '{1, 3, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0},
           '{1, 12, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0}};
    foreach (tv[i]) begin
      step(tv[i].kv, tv[i].kd, tv[i].kc);
      chk("tv_unlock", unlock_pulse, tv[i].eu);
      chk("tv_fail", fail_pulse, tv[i].ef);
      chk("tv_locked", locked, tv[i].el);
      chk("tv_count", digit_count, tv[i].ec);
    end
    // Test 3: two failures must not lock after the earlier success; third locks for LOCK cycles
    enter(16'h9999);
    enter(16'h9999);
    chk("no_lock_after_two", locked, 0);
    enter(16'h9999);
    chk("fail_with_lock", {fail_pulse, locked}, 2'b11);
    n = 1;
    while (locked === 1'b1 && n < 40) begin
      step(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (locked === 1'b1) n++;
    end
    chk("lock_len", n, LOCK);
    enter(16'h1234);
    chk("unlock_after_lock", unlock_pulse, 1);
    // Test 4: timeout boundary, then an entry that still unlocks
    step(1, 1, 0);
    step(1, 2, 0);
    repeat (TMO - 1) step(0, 0, 0);
    chk("before_timeout", digit_count, 2);
    step(0, 0, 0);
    chk("after_timeout", digit_count, 0);
    enter(16'h1234);
    chk("unlock_after_timeout", unlock_pulse, 1);
    // Test 6: asynchronous reset mid-entry and mid-lockout
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    async_reset();
    enter(16'h1234);
    chk("unlock_after_rst1", unlock_pulse, 1);
    repeat (3) enter(16'h9999);
    repeat (5) step(0, 0, 0);
    chk("mid_lock", locked, 1);
    async_reset();
    enter(16'h1234);
    chk("unlock_after_rst2", unlock_pulse, 1);
    // Random phase: pin_ref occasionally changes mid-entry to exercise latching
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) pin_ref = $urandom_range(0, 1) ? 16'h1234 : 16'h8061;
      if ($urandom_range(0, 60) == 0) repeat (TMO + 1) step(0, 0, 0);
      d = m_cnt == 0 ? pin_ref[15:12] : m_cnt < 4 ? m_ref[(3-m_cnt)*4 +: 4] : 4'd0;
      if ($urandom_range(0, 2) == 0) d = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 40) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
